// File: rtl/apb_bridge_pkg.sv
// rtl/apb_bridge_pkg.sv - shared state encoding and AHB response codes for the AHB-to-APB bridge
package apb_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WWAIT  = 3'd1,
    SETUP  = 3'd2,
    ACCESS = 3'd3,
    ERR1   = 3'd4,
    ERR2   = 3'd5
  } apb_state_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/apb_timeout_ctr.sv
// rtl/apb_timeout_ctr.sv - ACCESS wait-state counter; expired pulses on the inc that reaches limit
module apb_timeout_ctr #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + {{(W-1){1'b0}}, 1'b1};
    end
  end

  // Fires combinationally so the FSM aborts on the same edge that would make count == limit.
  assign expired = inc && (count == (limit - {{(W-1){1'b0}}, 1'b1}));

endmodule

// File: rtl/apb_master_ctrl.sv
// rtl/apb_master_ctrl.sv - APB-side bridge controller; optional ACCESS timeout under APB_TIMEOUT_EN
module apb_master_ctrl
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int NSLV      = 3,
  parameter int TO_CYCLES = 16
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              valid,
  input  logic              hwrite,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [DATA_W-1:0] hwdata,
  input  logic [NSLV-1:0]   tempselx,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic              pwrite,
  output logic              penable,
  output logic [NSLV-1:0]   pselx,
  output logic              hreadyout,
  output logic              hresp,
  output logic [DATA_W-1:0] hrdata
);

  apb_state_t      state, state_d;
  logic [NSLV-1:0] sel_q, sel_d;
  logic            accept;
  logic            expired;

`ifdef APB_TIMEOUT_EN
  apb_timeout_ctr #(.W(16)) u_timeout (
    .clk     (hclk),
    .rst_n   (hresetn),
    .clear   (state == SETUP),
    .inc     ((state == ACCESS) && !pready),
    .limit   (16'(TO_CYCLES)),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    state_d = state;
    accept  = valid && hreadyout && ((state == IDLE) || (state == ERR2));
    sel_d   = accept ? tempselx : sel_q;
    case (state)
      IDLE, ERR2: begin
        if (!accept)            state_d = IDLE;
        else if (tempselx == '0) state_d = ERR1;
        else if (hwrite)        state_d = WWAIT;
        else                    state_d = SETUP;
      end
      WWAIT:  state_d = SETUP;
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        if (pready)       state_d = pslverr ? ERR1 : IDLE;
        else if (expired) state_d = ERR1;
      end
      ERR1:    state_d = ERR2;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Outputs are registered decodes of the next state so they change exactly with the state.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      paddr     <= '0;
      pwdata    <= '0;
      pwrite    <= 1'b0;
      penable   <= 1'b0;
      pselx     <= '0;
      sel_q     <= '0;
      hreadyout <= 1'b1;
      hresp     <= HRESP_OKAY;
      hrdata    <= '0;
    end else begin
      hreadyout <= (state_d == IDLE) || (state_d == ERR2);
      hresp     <= ((state_d == ERR1) || (state_d == ERR2)) ? HRESP_ERROR : HRESP_OKAY;
      penable   <= (state_d == ACCESS);
      pselx     <= ((state_d == SETUP) || (state_d == ACCESS)) ? sel_d : '0;
      if (accept) begin
        paddr  <= haddr;
        pwrite <= hwrite;
        sel_q  <= tempselx;
      end
      if (state == WWAIT) pwdata <= hwdata;
      if ((state == ACCESS) && pready && !pslverr && !pwrite) hrdata <= prdata;
    end
  end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb/tb_apb_master_ctrl.sv - directed self-checking bench for apb_master_ctrl (timeout case follows APB_TIMEOUT_EN)
module tb_apb_master_ctrl;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        valid;
  logic        hwrite;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [2:0]  tempselx;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pwrite;
  logic        penable;
  logic [2:0]  pselx;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;

  int n_assert = 0;
  int n_fail   = 0;

  apb_master_ctrl #(.ADDR_W(32), .DATA_W(32), .NSLV(3), .TO_CYCLES(4)) dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .valid     (valid),
    .hwrite    (hwrite),
    .haddr     (haddr),
    .hwdata    (hwdata),
    .tempselx  (tempselx),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .pwrite    (pwrite),
    .penable   (penable),
    .pselx     (pselx),
    .hreadyout (hreadyout),
    .hresp     (hresp),
    .hrdata    (hrdata)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge hclk);
    #1;
  endtask

  initial begin
    hresetn = 1'b0; valid = 1'b0; hwrite = 1'b0; haddr = '0; hwdata = '0;
    tempselx = '0; prdata = '0; pready = 1'b1; pslverr = 1'b0;
    #12;
    chk("rst_hready",  {31'd0, hreadyout}, 32'd1);
    chk("rst_hresp",   {31'd0, hresp},     32'd0);
    chk("rst_psel",    {29'd0, pselx},     32'd0);
    chk("rst_penable", {31'd0, penable},   32'd0);
    chk("rst_paddr",   paddr,  32'd0);
    chk("rst_hrdata",  hrdata, 32'd0);
    hresetn = 1'b1;
    cyc();

    // 1: zero-wait read
    valid = 1'b1; hwrite = 1'b0; haddr = 32'h0000_1004; tempselx = 3'b010;
    prdata = 32'hCAFE_F00D; pready = 1'b1;
    cyc();
    chk("t1_setup_psel", {29'd0, pselx}, 32'h2);
    chk("t1_setup_pen",  {31'd0, penable}, 32'd0);
    chk("t1_setup_hrdy", {31'd0, hreadyout}, 32'd0);
    chk("t1_paddr",      paddr, 32'h0000_1004);
    valid = 1'b0;
    cyc();
    chk("t1_acc_psel", {29'd0, pselx}, 32'h2);
    chk("t1_acc_pen",  {31'd0, penable}, 32'd1);
    chk("t1_acc_hrdy", {31'd0, hreadyout}, 32'd0);
    cyc();
    chk("t1_done_psel", {29'd0, pselx}, 32'd0);
    chk("t1_done_hrdy", {31'd0, hreadyout}, 32'd1);
    chk("t1_done_hresp", {31'd0, hresp}, 32'd0);
    chk("t1_hrdata",    hrdata, 32'hCAFE_F00D);

    // 2: write with three pready=0 cycles (also pready winning at the timeout limit)
    valid = 1'b1; hwrite = 1'b1; haddr = 32'h0000_2008; tempselx = 3'b100; pready = 1'b0;
    cyc();
    chk("t2_wwait_hrdy", {31'd0, hreadyout}, 32'd0);
    chk("t2_wwait_psel", {29'd0, pselx}, 32'd0);
    valid = 1'b0; hwdata = 32'hA5A5_5A5A;
    cyc();
    chk("t2_setup_psel",  {29'd0, pselx}, 32'h4);
    chk("t2_setup_pen",   {31'd0, penable}, 32'd0);
    chk("t2_setup_pwdat", pwdata, 32'hA5A5_5A5A);
    hwdata = 32'h0;
    cyc();
    for (int i = 0; i < 4; i++) begin
      chk("t2_acc_pen",   {31'd0, penable}, 32'd1);
      chk("t2_acc_psel",  {29'd0, pselx}, 32'h4);
      chk("t2_acc_pwdat", pwdata, 32'hA5A5_5A5A);
      chk("t2_acc_paddr", paddr, 32'h0000_2008);
      chk("t2_acc_pwr",   {31'd0, pwrite}, 32'd1);
      chk("t2_acc_hrdy",  {31'd0, hreadyout}, 32'd0);
      if (i == 3) pready = 1'b1;
      cyc();
    end
    chk("t2_done_hrdy", {31'd0, hreadyout}, 32'd1);
    chk("t2_done_psel", {29'd0, pselx}, 32'd0);
    chk("t2_hrdata_kept", hrdata, 32'hCAFE_F00D);

    // 3: read completing with pslverr
    valid = 1'b1; hwrite = 1'b0; haddr = 32'h0000_3000; tempselx = 3'b001;
    prdata = 32'hDEAD_BEEF; pready = 1'b1; pslverr = 1'b1;
    cyc();
    valid = 1'b0;
    cyc();
    chk("t3_acc_pen", {31'd0, penable}, 32'd1);
    cyc();
    chk("t3_err1_hresp", {31'd0, hresp}, 32'd1);
    chk("t3_err1_hrdy",  {31'd0, hreadyout}, 32'd0);
    chk("t3_err1_psel",  {29'd0, pselx}, 32'd0);
    chk("t3_err1_pen",   {31'd0, penable}, 32'd0);
    pslverr = 1'b0;
    cyc();
    chk("t3_err2_hresp", {31'd0, hresp}, 32'd1);
    chk("t3_err2_hrdy",  {31'd0, hreadyout}, 32'd1);
    chk("t3_hrdata_kept", hrdata, 32'hCAFE_F00D);
    cyc();
    chk("t3_idle_hresp", {31'd0, hresp}, 32'd0);

    // 4: unmapped address
    valid = 1'b1; hwrite = 1'b0; haddr = 32'h0000_9000; tempselx = 3'b000;
    cyc();
    chk("t4_err1_psel",  {29'd0, pselx}, 32'd0);
    chk("t4_err1_hresp", {31'd0, hresp}, 32'd1);
    chk("t4_err1_hrdy",  {31'd0, hreadyout}, 32'd0);
    valid = 1'b0;
    cyc();
    chk("t4_err2_psel",  {29'd0, pselx}, 32'd0);
    chk("t4_err2_hresp", {31'd0, hresp}, 32'd1);
    chk("t4_err2_hrdy",  {31'd0, hreadyout}, 32'd1);
    cyc();
    chk("t4_idle_hresp", {31'd0, hresp}, 32'd0);
    chk("t4_idle_hrdy",  {31'd0, hreadyout}, 32'd1);

    // 5: back-to-back write then read with valid held high, then reset mid-ACCESS
    valid = 1'b1; hwrite = 1'b1; haddr = 32'h0000_4000; tempselx = 3'b010; pready = 1'b1;
    cyc();
    hwdata = 32'h1111_2222;
    hwrite = 1'b0; haddr = 32'h0000_5000; tempselx = 3'b001; prdata = 32'h5555_AAAA;
    cyc();
    chk("t5_w_setup_paddr", paddr, 32'h0000_4000);
    chk("t5_w_setup_pwr",   {31'd0, pwrite}, 32'd1);
    chk("t5_w_pwdata",      pwdata, 32'h1111_2222);
    cyc();
    chk("t5_w_acc_pen", {31'd0, penable}, 32'd1);
    cyc();
    chk("t5_done_hrdy", {31'd0, hreadyout}, 32'd1);
    chk("t5_done_psel", {29'd0, pselx}, 32'd0);
    cyc();
    chk("t5_r_setup_psel",  {29'd0, pselx}, 32'h1);
    chk("t5_r_setup_paddr", paddr, 32'h0000_5000);
    chk("t5_r_setup_pwr",   {31'd0, pwrite}, 32'd0);
    valid = 1'b0; pready = 1'b0;
    cyc();
    chk("t5_r_acc_pen",   {31'd0, penable}, 32'd1);
    chk("t5_r_acc_pwdat", pwdata, 32'h1111_2222);
    #2 hresetn = 1'b0;
    #1;
    chk("t5_rst_psel",  {29'd0, pselx}, 32'd0);
    chk("t5_rst_pen",   {31'd0, penable}, 32'd0);
    chk("t5_rst_hrdy",  {31'd0, hreadyout}, 32'd1);
    chk("t5_rst_paddr", paddr, 32'd0);
    chk("t5_rst_pwdat", pwdata, 32'd0);
    chk("t5_rst_hrdat", hrdata, 32'd0);
    #2 hresetn = 1'b1;
    cyc();
    chk("t5_post_psel", {29'd0, pselx}, 32'd0);

    // 6: pready stuck low
    valid = 1'b1; hwrite = 1'b0; haddr = 32'h0000_6000; tempselx = 3'b100;
    prdata = 32'h0BAD_CAFE; pready = 1'b0;
    cyc();
    valid = 1'b0;
    cyc();
    for (int i = 0; i < 4; i++) begin
      chk("t6_acc_pen", {31'd0, penable}, 32'd1);
      cyc();
    end
`ifdef APB_TIMEOUT_EN
    chk("t6_to_hresp", {31'd0, hresp}, 32'd1);
    chk("t6_to_hrdy",  {31'd0, hreadyout}, 32'd0);
    chk("t6_to_psel",  {29'd0, pselx}, 32'd0);
    chk("t6_to_pen",   {31'd0, penable}, 32'd0);
    cyc();
    chk("t6_err2_hresp", {31'd0, hresp}, 32'd1);
    chk("t6_err2_hrdy",  {31'd0, hreadyout}, 32'd1);
    cyc();
    chk("t6_idle_hresp", {31'd0, hresp}, 32'd0);
    chk("t6_hrdata_kept", hrdata, 32'd0);
`else
    for (int i = 0; i < 96; i++) cyc();
    chk("t6_wait_pen",  {31'd0, penable}, 32'd1);
    chk("t6_wait_psel", {29'd0, pselx}, 32'h4);
    chk("t6_wait_hrdy", {31'd0, hreadyout}, 32'd0);
    pready = 1'b1;
    cyc();
    chk("t6_done_hrdy", {31'd0, hreadyout}, 32'd1);
    chk("t6_hrdata",    hrdata, 32'h0BAD_CAFE);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
